multiplier_arbiter: RTL and testbench
=====================================

MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one multiplier_booth instance.
REQ-002 Parameter WIDTH, default 16, operand/result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N_REQ  per-requester request level; bit i high = requester i wants one multiply.
REQ-006 req_a  input  N_REQ*WIDTH  packed operand A; slice i belongs to requester i.
REQ-007 req_b  input  N_REQ*WIDTH  packed operand B; slice i belongs to requester i.
REQ-008 done  output  N_REQ  one-cycle completion pulse, bit i for requester i.
REQ-009 result  output  WIDTH  registered product of the last completed operation.
REQ-010 overflow  output  1  registered overflow flag of the last completed operation.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 grant_id  output  clog2(N_REQ)  index of the requester currently or last served.
REQ-013 mul_a, mul_b  output  WIDTH each  registered operands driven to the multiplier.
REQ-014 mul_start  output  1  start level to the multiplier.
REQ-015 mul_result  input  WIDTH  multiplier result.
REQ-016 mul_overflow  input  1  multiplier overflow flag.
REQ-017 mul_finish  input  1  multiplier finish flag.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY, and DRAIN.
REQ-019 IDLE with any req bit high: at the rising edge, the arbiter SHALL select a winner round-robin, starting the search at ptr and wrapping from N_REQ-1 to 0.
REQ-020 At that same edge: latch the winner's req_a/req_b into mul_a/mul_b, set grant_id = winner, set ptr = (winner+1) mod N_REQ, set mul_start=1, and go to BUSY.
REQ-021 IDLE with req all zero SHALL hold state; mul_start=0.
REQ-022 BUSY: mul_a, mul_b and mul_start=1 SHALL be held stable; changes on req, req_a or req_b SHALL be ignored.
REQ-023 BUSY with mul_finish=1 at an edge: latch mul_result into result and mul_overflow into overflow, pulse done[grant_id] high for exactly the next cycle, drive mul_start=0, and go to DRAIN.
REQ-024 DRAIN SHALL go to IDLE at the first edge where mul_finish=0; otherwise it SHALL stay in DRAIN with mul_start=0, so a level-held finish is never double-counted.
REQ-025 Latency from the IDLE edge that grants a request to the done pulse SHALL be the multiplier latency plus 1 cycle; after done, DRAIN lasts at least 1 cycle before the next grant.
REQ-026 Requester protocol: req_a/req_b stable while req is high until done. If req is withdrawn mid-operation, the arbiter SHALL still complete, update result/overflow and pulse done.
REQ-027 At most one done bit SHALL be high in any cycle.
REQ-028 result and overflow SHALL change only on the completion edge and otherwise hold their values.
REQ-029 Requests arriving during BUSY/DRAIN SHALL wait; no request is lost while its req stays high.

Reset
REQ-030 rst high SHALL immediately force: state=IDLE, ptr=0, grant_id=0, done=0, result=0, overflow=0, mul_a=0, mul_b=0, mul_start=0, busy=0.
REQ-031 Reset mid-BUSY SHALL abandon the operation with no done pulse; the multiplier receives the same rst.
REQ-032 After rst deasserts, the first grant SHALL go to the lowest-index active requester.

Verification
Bench uses a multiplier stub: finish rises 16 cycles after start, result = A^B, overflow = A[15]; finish stays high while start is high.
REQ-033 Single request: req=0001, a0=0x1234, b0=0x00FF -> mul_start 1 cycle later; done=0001 pulsed once; result=0x12CB; overflow=0.
REQ-034 All four requesters held high together -> grant order 0,1,2,3; exactly four done pulses; each result equals that requester's A^B.
REQ-035 After requester 2 is served, req=0101 -> next grant is requester 0 (wrap), then requester 2.
REQ-036 rst asserted 5 cycles into BUSY -> all outputs 0 immediately; no done pulse; a new req=0010 after reset is granted to requester 1 and completes normally.
REQ-037 Stub holds finish high 3 extra cycles after start drops -> exactly one done pulse; DRAIN lasts until finish is low; no regrant during DRAIN.
REQ-038 req0 withdrawn mid-BUSY with a0=0x8000, b0=0x0001 -> done[0] still pulses; result=0x8001; overflow=1.

Source files
------------

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among N_REQ
// requesters; three-state control with a drain phase for level finish.
module multiplier_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   overflow,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  output logic                   mul_start,
  input  logic [WIDTH-1:0]       mul_result,
  input  logic                   mul_overflow,
  input  logic                   mul_finish
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [IDW-1:0]   LAST = IDW'(N_REQ - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   ptr_nxt;
  logic             found;
  logic             grant;
  logic             finish;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // Round-robin search: first active request at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      automatic int idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Winner operands and the pointer one past the winner.
  always_comb begin
    win_a   = req_a[winner*WIDTH +: WIDTH];
    win_b   = req_b[winner*WIDTH +: WIDTH];
    ptr_nxt = (winner == LAST) ? '0 : winner + 1'b1;
  end

  assign grant  = (state == IDLE) && found;
  assign finish = (state == BUSY) && mul_finish;
  assign busy   = (state != IDLE);

  // Next-state logic; DRAIN waits out a level-held finish.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (mul_finish) state_nxt = DRAIN;
      DRAIN:   if (!mul_finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant bookkeeping: pointer, served index and operands latch on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      grant_id <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else if (grant) begin
      ptr      <= ptr_nxt;
      grant_id <= winner;
      mul_a    <= win_a;
      mul_b    <= win_b;
    end
  end

  // Start level: raised on grant, held through BUSY, dropped on finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mul_start <= 1'b0;
    else if (grant)  mul_start <= 1'b1;
    else if (finish) mul_start <= 1'b0;
    else if (state != BUSY) mul_start <= 1'b0;
  end

  // Completion capture: result and overflow change only here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if (finish) begin
      result   <= mul_result;
      overflow <= mul_overflow;
    end
  end

  // One-cycle done pulse for the served requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         done <= '0;
    else if (finish) done <= ONE << grant_id;
    else             done <= '0;
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter with a 16-cycle XOR multiplier
// stub whose finish can be held extra cycles after start drops.
module tb_multiplier_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  done;
  logic [15:0] result;
  logic        overflow;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_start;
  logic [15:0] mul_result;
  logic        mul_overflow;
  logic        mul_finish;

  int n_tests = 0;
  int n_fail  = 0;
  int done_total = 0;
  int multi_done = 0;
  int extra = 0;

  multiplier_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .done(done), .result(result), .overflow(overflow), .busy(busy),
    .grant_id(grant_id), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_result(mul_result),
    .mul_overflow(mul_overflow), .mul_finish(mul_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] scnt;
  logic [3:0] drop;

  assign mul_result   = mul_a ^ mul_b;
  assign mul_overflow = mul_a[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      drop <= '0;
      mul_finish <= 1'b0;
    end else if (mul_start) begin
      drop <= '0;
      if (scnt < 5'd16) scnt <= scnt + 5'd1;
      if (scnt >= 5'd15) mul_finish <= 1'b1;
    end else begin
      scnt <= '0;
      if (mul_finish) begin
        if (int'(drop) >= extra) mul_finish <= 1'b0;
        else drop <= drop + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (done != 4'b0) done_total++;
    if ($countones(done) > 1) multi_done++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic wait_done(input string tag, output logic [3:0] d,
                           output int lat);
    d = 4'b0;
    lat = 0;
    while (lat < 100 && d == 4'b0) begin
      @(negedge clk);
      lat++;
      d = done;
    end
    if (d == 4'b0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  logic [3:0] d;
  int lat;
  int snap;
  int dc;

  initial begin
    rst = 1'b1;
    req = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", mul_start, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_mula", mul_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // single request
    set_op(0, 16'h1234, 16'h00FF);
    req = 4'b0001;
    @(negedge clk);
    check("t1_start", mul_start, 1);
    check("t1_mula", mul_a, 16'h1234);
    check("t1_mulb", mul_b, 16'h00FF);
    check("t1_gid", grant_id, 0);
    wait_done("t1", d, lat);
    check("t1_lat", lat, 17);
    check("t1_done", d, 4'b0001);
    check("t1_res", result, 16'h12CB);
    check("t1_ovf", overflow, 0);
    req = 4'b0000;
    @(negedge clk);
    check("t1_pulse", done, 0);
    check("t1_drain", busy, 1);
    wait_idle("t1");

    // all four held: order 0,1,2,3 from fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_op(0, 16'h1111, 16'h0F0F);
    set_op(1, 16'hABCD, 16'h00FF);
    set_op(2, 16'h5555, 16'hFFFF);
    set_op(3, 16'h8000, 16'h7FFF);
    snap = done_total;
    req = 4'b1111;
    wait_done("t2a", d, lat);
    check("t2_d0", d, 4'b0001);
    check("t2_r0", result, 16'h1E1E);
    req[0] = 1'b0;
    wait_done("t2b", d, lat);
    check("t2_d1", d, 4'b0010);
    check("t2_r1", result, 16'hAB32);
    req[1] = 1'b0;
    wait_done("t2c", d, lat);
    check("t2_d2", d, 4'b0100);
    check("t2_r2", result, 16'hAAAA);
    req[2] = 1'b0;
    wait_done("t2d", d, lat);
    check("t2_d3", d, 4'b1000);
    check("t2_r3", result, 16'hFFFF);
    check("t2_o3", overflow, 1);
    req[3] = 1'b0;
    wait_idle("t2");
    check("t2_count", done_total - snap, 4);

    // wrap: after 2 served, 0101 -> 0 then 2
    req = 4'b0100;
    wait_done("t3a", d, lat);
    check("t3_d2", d, 4'b0100);
    req = 4'b0101;
    wait_done("t3b", d, lat);
    check("t3_wrap", d, 4'b0001);
    check("t3_gid", grant_id, 0);
    check("t3_r0", result, 16'h1E1E);
    req = 4'b0100;
    wait_done("t3c", d, lat);
    check("t3_d2b", d, 4'b0100);
    req = 4'b0000;
    wait_idle("t3");

    // reset mid-BUSY
    req = 4'b0001;
    @(negedge clk);
    repeat (5) @(negedge clk);
    snap = done_total;
    rst = 1'b1;
    #1;
    check("t4_busy", busy, 0);
    check("t4_start", mul_start, 0);
    check("t4_mula", mul_a, 0);
    check("t4_res", result, 0);
    check("t4_gid", grant_id, 0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t4_nodone", done_total - snap, 0);
    req = 4'b0010;
    wait_done("t4", d, lat);
    check("t4_d1", d, 4'b0010);
    check("t4_g1", grant_id, 1);
    check("t4_r1", result, 16'hAB32);
    req = 4'b0000;
    wait_idle("t4");

    // finish held 3 extra cycles; no regrant during drain
    extra = 3;
    snap = done_total;
    req = 4'b0011;
    wait_done("t5a", d, lat);
    check("t5_d0", d, 4'b0001);
    req = 4'b0010;
    dc = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_start) break;
      if (busy) dc++;
    end
    check("t5_drain", dc, 5);
    wait_done("t5b", d, lat);
    check("t5_d1", d, 4'b0010);
    req = 4'b0000;
    wait_idle("t5");
    check("t5_count", done_total - snap, 2);
    extra = 0;

    // withdraw req mid-BUSY
    set_op(0, 16'h8000, 16'h0001);
    req = 4'b0001;
    repeat (4) @(negedge clk);
    req = 4'b0000;
    wait_done("t6", d, lat);
    check("t6_d0", d, 4'b0001);
    check("t6_res", result, 16'h8001);
    check("t6_ovf", overflow, 1);
    wait_idle("t6");

    check("multi_done", multi_done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
